// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU configuration encodings and default datapath widths.
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [3:0] AND_CONF = 4'b0000;
    localparam logic [3:0] OR_CONF  = 4'b0001;
    localparam logic [3:0] ADD_CONF = 4'b0010;
    localparam logic [3:0] SUB_CONF = 4'b0011;
    localparam logic [3:0] SLT_CONF = 4'b0100;
    localparam logic [3:0] NOR_CONF = 4'b0101;
    localparam logic [3:0] XOR_CONF = 4'b0110;
    localparam logic [3:0] SLL_CONF = 4'b0111;
    localparam logic [3:0] SRL_CONF = 4'b1000;
    localparam logic [3:0] SRA_CONF = 4'b1001;

endpackage

// File: rtl/alu_core.sv
// Purely combinational MIPS ALU: logic, add/sub, set-less-than and shifts,
// with signed overflow detection for add/sub.
module alu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [3:0]        alu_conf,
    input  logic              sign,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              lt;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt   = sign ? ($signed(a) < $signed(b)) : (a < b);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_conf)
            AND_CONF: result = a & b;
            OR_CONF:  result = a | b;
            ADD_CONF: begin
                result   = sum;
                overflow = sign && (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            SUB_CONF: begin
                result   = diff;
                overflow = sign && (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            SLT_CONF: result = {{(DATA_W-1){1'b0}}, lt};
            NOR_CONF: result = ~(a | b);
            XOR_CONF: result = a ^ b;
            SLL_CONF: result = b << shamt;
            SRL_CONF: result = b >> shamt;
            SRA_CONF: result = $signed(b) >>> shamt;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU on forwarded operands, combinational branch zero flag,
// and the EX/MEM pipeline register with flush/stall and overflow masking.
module ex_alu_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        alu_conf,
    input  logic              sign,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        shamt,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [REG_AW-1:0] in_wb_dst,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              zero,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              out_overflow,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [REG_AW-1:0] out_wb_dst,
    output logic [DATA_W-1:0] out_store_data
);

    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .alu_conf (alu_conf),
        .sign     (sign),
        .a        (op_a),
        .b        (op_b),
        .shamt    (shamt),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    assign zero = (alu_result == '0);

    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] result_q,     result_d;
    logic              overflow_q,   overflow_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic [REG_AW-1:0] wb_dst_q,     wb_dst_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;

    // Default is hold (stall); flush overrides stall, and a plain load gates
    // side effects by in_valid and suppresses writes of an overflowing op.
    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        overflow_d   = overflow_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        wb_dst_d     = wb_dst_q;
        store_data_d = store_data_q;
        if (flush) begin
            valid_d      = 1'b0;
            result_d     = '0;
            overflow_d   = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            wb_dst_d     = '0;
            store_data_d = '0;
        end else if (!stall) begin
            valid_d      = in_valid;
            result_d     = alu_result;
            overflow_d   = alu_ovf & in_valid;
            reg_write_d  = in_reg_write & in_valid & ~alu_ovf;
            mem_read_d   = in_mem_read & in_valid;
            mem_write_d  = in_mem_write & in_valid & ~alu_ovf;
            wb_dst_d     = in_wb_dst;
            store_data_d = in_store_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wb_dst_q     <= '0;
            store_data_q <= '0;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            wb_dst_q     <= wb_dst_d;
            store_data_q <= store_data_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_overflow   = overflow_q;
    assign out_reg_write  = reg_write_q;
    assign out_mem_read   = mem_read_q;
    assign out_mem_write  = mem_write_q;
    assign out_wb_dst     = wb_dst_q;
    assign out_store_data = store_data_q;

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute-stage datapath directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU configuration and the sign flag, computes the result on the forwarded operands, and registers it with the control bits into the EX/MEM pipeline register.
- Provides a combinational zero flag for branch resolution in EX.
- Detects signed add/sub overflow and suppresses writeback for the overflowing instruction.

Parameters:
- DATA_W, 32, datapath width (fixed at 32 for MIPS; any other value is unsupported).
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a live instruction
- stall  in  1  hold EX/MEM contents (downstream not accepting)
- flush  in  1  kill the instruction entering EX/MEM
- alu_conf  in  4  operation select from ALU control
- sign  in  1  1 = signed compare/overflow semantics
- op_a  in  DATA_W  forwarded operand A (rs)
- op_b  in  DATA_W  forwarded operand B (rt or extended immediate)
- shamt  in  5  shift amount
- in_reg_write  in  1  writeback enable
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_wb_dst  in  REG_AW  destination register
- in_store_data  in  DATA_W  rt value for stores
- zero  out  1  combinational: current ALU result == 0
- out_valid  out  1  EX/MEM valid
- out_result  out  DATA_W  registered ALU result
- out_overflow  out  1  registered signed-overflow flag
- out_reg_write  out  1  registered, overflow-masked
- out_mem_read  out  1  registered
- out_mem_write  out  1  registered, overflow-masked
- out_wb_dst  out  REG_AW  registered
- out_store_data  out  DATA_W  registered

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset: all registered outputs are 0 (out_valid=0, out_result=0, out_overflow=0, all control bits 0).
- ALU operation encodings:
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b
  - 0011 SUB: a - b
  - 0100 SLT: 1 if a < b, signed when sign=1, unsigned when sign=0; upper 31 bits zero
  - 0101 NOR: ~(a | b)
  - 0110 XOR: a ^ b
  - 0111 SLL: b << shamt
  - 1000 SRL: b >> shamt, logical
  - 1001 SRA: b >>> shamt, arithmetic
  - 1010-1111: result 0, no overflow
- Add/sub wrap modulo 2^32.
- Overflow is asserted only for ADD/SUB with sign=1:
  - ADD: operand signs equal and result sign differs from them.
  - SUB: operand signs differ and result sign differs from a.
- zero is purely combinational from the current inputs, independent of in_valid, stall and flush.
- Latency: 1 cycle from inputs to out_* registers.
- Per-edge priority: reset > flush > stall > load.
  - flush=1: out_valid<=0 and all control bits <=0; data fields don't-care (implementation clears them to 0). Flush wins over a simultaneous stall.
  - stall=1 (no flush): every out_* register holds its value.
  - Otherwise: load.
    - out_valid <= in_valid.
    - Control bits are ANDed with in_valid, so an invalid slot carries no side effects.
    - out_reg_write and out_mem_write are additionally ANDed with ~overflow.
    - out_mem_read is not masked.
    - out_overflow is loaded as computed, ANDed with in_valid.
- Shift amount 0 passes b unchanged. shamt is used as-is; no masking from op_a.
- Reset asserted mid-stall clears everything immediately. The first edge after release behaves as a normal load.

Decomposition:
- Shared package cpu_pkg holds:
  - ALUConf constants (AND_CONF..SRA_CONF, 4-bit)
  - DATA_W and REG_AW defaults
- Natural sub-module: alu_core, purely combinational (alu_conf, sign, a, b, shamt -> result, overflow).
- ex_alu_stage adds the zero detect and the EX/MEM register with stall/flush/masking.

Test Plan:
- ADD signed: a=0x7FFFFFFF, b=1, sign=1, in_reg_write=1 -> next cycle out_result=0x80000000, out_overflow=1, out_reg_write=0, out_valid=1. Same inputs with sign=0 -> overflow 0, reg_write 1.
- SLT: a=0xFFFFFFFF, b=1; sign=1 -> out_result=1; sign=0 -> out_result=0.
- Shifts: b=0x80000010, shamt=4. SLL -> 0x00000100; SRL -> 0x08000001; SRA -> 0xF8000001. shamt=0 -> 0x80000010.
- Branch zero: SUB a=b=0x1234 -> zero=1 combinationally in the same cycle; a=0x1234, b=0x1235 -> zero=0.
- Stall/flush:
  - Load ADD result 5; assert stall 3 cycles with new inputs -> out_result stays 5.
  - stall=1 and flush=1 together -> out_valid=0 and out_reg_write=0 next edge.
  - in_valid=0 with in_mem_write=1 -> out_mem_write=0.
- Reset: drive rst_n low asynchronously between edges while out_valid=1 -> all outputs 0 immediately, held until release.
